// File: rtl/mtime_counter.sv
// mtime_counter: free-running 64-bit machine timebase, mtimecmp register and machine timer interrupt.
// Optional MTIME_RTC_SYNC_EN: count synchronized RtcTick rising edges instead of the clk prescaler.
module mtime_counter #(
  parameter int XLEN       = 64,
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            HaltReq,
  output logic            HaltAck,
  input  logic            WrEn,
  input  logic [1:0]      WrAdr,
  input  logic [XLEN-1:0] WrData,
  output logic            Tick,
  output logic [63:0]     MTIME_CLINT,
  output logic [63:0]     MTIMECMP,
  output logic            MTimerInt
`ifdef MTIME_RTC_SYNC_EN
  ,
  input  logic            RtcTick
`endif
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   run;

  // HaltReq/HaltAck is a level request/acknowledge pair: HaltAck rises at the edge that sees
  // HaltReq high and falls at the edge that sees it low; HaltAck mirrors the FSM state exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (HaltReq)  state_d = ST_HALTED;
      ST_HALTED: if (!HaltReq) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  assign HaltAck = (state_q == ST_HALTED);
  assign run     = (state_q == ST_RUN);

  // Write decode; in RV32 each address owns one 32-bit half, the other half holds.
  logic        mtime_wr;
  logic [63:0] mtime_load;
  logic [63:0] cmp_d;

  always_comb begin
    mtime_wr   = 1'b0;
    mtime_load = MTIME_CLINT;
    cmp_d      = MTIMECMP;
    if (WrEn) begin
      if (XLEN == 64) begin
        if (WrAdr == 2'd0) begin
          mtime_wr   = 1'b1;
          mtime_load = 64'(WrData);
        end else if (WrAdr == 2'd2) begin
          cmp_d = 64'(WrData);
        end
      end else begin
        case (WrAdr)
          2'd0: begin
            mtime_wr          = 1'b1;
            mtime_load[31:0]  = WrData[31:0];
          end
          2'd1: begin
            mtime_wr          = 1'b1;
            mtime_load[63:32] = WrData[31:0];
          end
          2'd2:    cmp_d[31:0]  = WrData[31:0];
          default: cmp_d[63:32] = WrData[31:0];
        endcase
      end
    end
  end

`ifdef MTIME_RTC_SYNC_EN
  logic rtc_s1;
  logic rtc_s2;
  logic rtc_s3;
  logic rtc_rise_q;

  // Two-flop synchronizer plus a registered rising-edge detect: RtcTick rise to Tick is 3 clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rtc_s1     <= 1'b0;
      rtc_s2     <= 1'b0;
      rtc_s3     <= 1'b0;
      rtc_rise_q <= 1'b0;
    end else begin
      rtc_s1     <= RtcTick;
      rtc_s2     <= rtc_s1;
      rtc_s3     <= rtc_s2;
      rtc_rise_q <= rtc_s2 & ~rtc_s3;
    end
  end

  // A rise that lands while halted is simply dropped.
  assign Tick = rtc_rise_q & run;
`else
  localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_cnt;

  // Gated by resetn so Tick reads 0 while reset is held, even with PRESCALE=1.
  assign Tick = resetn & run & (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt <= '0;
    end else if (mtime_wr || Tick) begin
      pre_cnt <= '0;
    end else if (run) begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end
`endif

  // A software load of mtime wins over the increment of the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MTIME_CLINT <= 64'd0;
      MTIMECMP    <= 64'hFFFF_FFFF_FFFF_FFFF;
      MTimerInt   <= 1'b0;
    end else begin
      if (mtime_wr) begin
        MTIME_CLINT <= mtime_load;
      end else if (Tick) begin
        MTIME_CLINT <= MTIME_CLINT + 64'd1;
      end
      MTIMECMP  <= cmp_d;
      MTimerInt <= (MTIME_CLINT >= MTIMECMP);
    end
  end

endmodule
